// File: rtl/pipeline_types.sv
// Shared types for the decoder pipeline: edge strobes, pulse timer states and
// the result record carried between pulse timing and symbol decoding.
package pipeline_types;

  localparam int PULSE_WIDTH = 10;

  typedef struct packed {
    logic rising;
    logic falling;
  } edges_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pulse_state_e;

  typedef struct packed {
    logic [PULSE_WIDTH-1:0] high_time;
    logic [PULSE_WIDTH-1:0] low_time;
    logic [1:0]             overflow;
    logic                   timeout;
  } pulse_result_t;

endpackage

// File: rtl/phase_counter.sv
// Enabled-cycle counter shared by the high and low phases. o_sat_hit marks an
// increment attempted while the counter already sits at all-ones.
module phase_counter #(
  parameter int WIDTH    = 10,
  parameter int SATURATE = 1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic             i_force_sat,
  output logic [WIDTH-1:0] o_count,
  output logic             o_sat_hit
);

  logic [WIDTH-1:0] r_count;
  logic             w_all_ones;

  assign w_all_ones = &r_count;
  assign o_sat_hit  = i_enable && !i_clear && w_all_ones;
  assign o_count    = r_count;

  // i_force_sat makes the counter hold at all-ones even in wrap mode
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      if (!w_all_ones) begin
        r_count <= r_count + WIDTH'(1);
      end else if (SATURATE == 0 && !i_force_sat) begin
        r_count <= '0;
      end
    end
  end

endmodule

// File: rtl/pulse_timer.sv
// Per-pulse timing engine: measures high and low phases of a serial line from
// its edge strobes and hands out {high, low} pairs through a 1-deep register.
module pulse_timer
  import pipeline_types::*;
#(
  parameter int WIDTH    = 10,
  parameter int TIMEOUT  = 400,
  parameter int SATURATE = 1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_count_enable,
  input  edges_t           i_edges,
  input  logic             i_clear,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_high_time,
  output logic [WIDTH-1:0] o_low_time,
  output logic [1:0]       o_overflow,
  output logic             o_timeout,
  output logic             o_overrun,
  output logic [WIDTH-1:0] o_timer_value
);

  localparam logic [WIDTH-1:0] TIMEOUT_LAST = WIDTH'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] TIMEOUT_TIME = WIDTH'(TIMEOUT);

  pulse_state_e     r_state, w_state_next;
  logic [WIDTH-1:0] w_count, w_emit_low;
  logic             w_sat_hit, w_cnt_clear, w_force_sat, w_cap_high, w_clr_flags;
  logic             w_emit, w_emit_timeout;
  logic             r_high_sat, r_low_sat;
  logic [WIDTH-1:0] r_high_cap;
  logic             r_valid, r_timeout, r_overrun;
  logic [WIDTH-1:0] r_high_time, r_low_time;
  logic [1:0]       r_overflow;

  phase_counter #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_counter (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_clear     (w_cnt_clear),
    .i_enable    (i_count_enable),
    .i_force_sat (w_force_sat),
    .o_count     (w_count),
    .o_sat_hit   (w_sat_hit)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= IDLE;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_clear    = 1'b0;
    w_force_sat    = 1'b0;
    w_cap_high     = 1'b0;
    w_clr_flags    = 1'b0;
    w_emit         = 1'b0;
    w_emit_timeout = 1'b0;
    w_emit_low     = w_count;
    if (i_clear || (i_edges.rising && i_edges.falling)) begin
      w_state_next = IDLE;
      w_cnt_clear  = 1'b1;
      w_clr_flags  = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          w_force_sat = 1'b1;
          if (i_edges.rising) begin
            w_state_next = HIGH;
            w_cnt_clear  = 1'b1;
            w_clr_flags  = 1'b1;
          end
        end
        HIGH: begin
          if (i_edges.falling) begin
            w_state_next = LOW;
            w_cnt_clear  = 1'b1;
            w_cap_high   = 1'b1;
          end else if (i_edges.rising) begin
            w_cnt_clear  = 1'b1;
            w_clr_flags  = 1'b1;
          end
        end
        LOW: begin
          if (i_edges.rising) begin
            w_state_next = HIGH;
            w_cnt_clear  = 1'b1;
            w_clr_flags  = 1'b1;
            w_emit       = 1'b1;
          end else if (i_count_enable && w_count == TIMEOUT_LAST) begin
            w_state_next   = IDLE;
            w_emit         = 1'b1;
            w_emit_timeout = 1'b1;
            w_emit_low     = TIMEOUT_TIME;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Phase flags accumulate only while a phase is actually being measured
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_high_sat <= 1'b0;
      r_low_sat  <= 1'b0;
      r_high_cap <= '0;
    end else begin
      if (w_cap_high) r_high_cap <= w_count;
      if (w_clr_flags) begin
        r_high_sat <= 1'b0;
        r_low_sat  <= 1'b0;
      end else begin
        if (r_state == HIGH && w_sat_hit) r_high_sat <= 1'b1;
        if (r_state == LOW && w_sat_hit)  r_low_sat  <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_valid     <= 1'b0;
      r_high_time <= '0;
      r_low_time  <= '0;
      r_overflow  <= '0;
      r_timeout   <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (i_clear) begin
      r_valid     <= 1'b0;
      r_high_time <= '0;
      r_low_time  <= '0;
      r_overflow  <= '0;
      r_timeout   <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_emit) begin
      if (r_valid && !i_ready) begin
        r_overrun <= 1'b1;
      end else begin
        r_valid     <= 1'b1;
        r_high_time <= r_high_cap;
        r_low_time  <= w_emit_low;
        r_overflow  <= {r_low_sat, r_high_sat};
        r_timeout   <= w_emit_timeout;
      end
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid       = r_valid;
  assign o_high_time   = r_high_time;
  assign o_low_time    = r_low_time;
  assign o_overflow    = r_overflow;
  assign o_timeout     = r_timeout;
  assign o_overrun     = r_overrun;
  assign o_timer_value = w_count;

endmodule

// File: tb/tb_pulse_timer.sv
// Self-checking bench: three pulse_timer variants on shared stimulus, checked by
// table vectors, directed corner sequences and a randomized run against a model.
module tb_pulse_timer;
  import pipeline_types::*;

  logic   clk = 1'b0;
  always #5 clk = ~clk;

  logic   rst_n = 1'b0, en = 1'b0, clr = 1'b0, rdy = 1'b0;
  edges_t edg = '0;

  logic       v0, v1, v2, to0, to1, to2, or0, or1, or2;
  logic [9:0] h0, l0, t0;
  logic [3:0] h1, l1, t1, h2, l2, t2;
  logic [1:0] f0, f1, f2;

  pulse_timer #(.WIDTH(10), .TIMEOUT(400), .SATURATE(1)) u_w10 (
    .i_clk(clk), .i_reset_n(rst_n), .i_count_enable(en), .i_edges(edg), .i_clear(clr),
    .i_ready(rdy), .o_valid(v0), .o_high_time(h0), .o_low_time(l0), .o_overflow(f0),
    .o_timeout(to0), .o_overrun(or0), .o_timer_value(t0));
  pulse_timer #(.WIDTH(4), .TIMEOUT(15), .SATURATE(1)) u_w4s (
    .i_clk(clk), .i_reset_n(rst_n), .i_count_enable(en), .i_edges(edg), .i_clear(clr),
    .i_ready(rdy), .o_valid(v1), .o_high_time(h1), .o_low_time(l1), .o_overflow(f1),
    .o_timeout(to1), .o_overrun(or1), .o_timer_value(t1));
  pulse_timer #(.WIDTH(4), .TIMEOUT(15), .SATURATE(0)) u_w4w (
    .i_clk(clk), .i_reset_n(rst_n), .i_count_enable(en), .i_edges(edg), .i_clear(clr),
    .i_ready(rdy), .o_valid(v2), .o_high_time(h2), .o_low_time(l2), .o_overflow(f2),
    .o_timeout(to2), .o_overrun(or2), .o_timer_value(t2));

  logic       a_valid[3], a_to[3], a_ovr[3];
  logic [9:0] a_high[3], a_low[3], a_timer[3];
  logic [1:0] a_ovf[3];
  assign a_valid[0] = v0;  assign a_valid[1] = v1;  assign a_valid[2] = v2;
  assign a_to[0]    = to0; assign a_to[1]    = to1; assign a_to[2]    = to2;
  assign a_ovr[0]   = or0; assign a_ovr[1]   = or1; assign a_ovr[2]   = or2;
  assign a_ovf[0]   = f0;  assign a_ovf[1]   = f1;  assign a_ovf[2]   = f2;
  assign a_high[0]  = h0;  assign a_high[1]  = {6'd0, h1}; assign a_high[2]  = {6'd0, h2};
  assign a_low[0]   = l0;  assign a_low[1]   = {6'd0, l1}; assign a_low[2]   = {6'd0, l2};
  assign a_timer[0] = t0;  assign a_timer[1] = {6'd0, t1}; assign a_timer[2] = {6'd0, t2};

  int P_W[3]   = '{10, 4, 4};
  int P_TO[3]  = '{400, 15, 15};
  int P_SAT[3] = '{1, 1, 0};

  // Model: unbounded enabled-cycle count since the last accepted edge; captured
  // values and flags are derived from it arithmetically.
  int       m_n[3], m_ph[3], m_caph[3], m_hi[3], m_lo[3];
  bit       m_caphs[3], m_vld[3], m_ovr[3], m_to[3];
  bit [1:0] m_ovf[3];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic int max_of(int k);
    return (1 << P_W[k]) - 1;
  endfunction

  function automatic int cap_val(int k, int n);
    if (P_SAT[k] != 0) return (n > max_of(k)) ? max_of(k) : n;
    return n % (max_of(k) + 1);
  endfunction

  function automatic void model_step(int k);
    bit       emit = 1'b0, eto = 1'b0;
    int       elow = 0;
    bit [1:0] eovf = 2'b00;
    if (!rst_n || clr) begin
      m_n[k] = 0; m_ph[k] = 0; m_vld[k] = 1'b0; m_ovr[k] = 1'b0;
      return;
    end
    if (edg.rising && edg.falling) begin
      m_n[k] = 0; m_ph[k] = 0;
    end else if (m_ph[k] == 0) begin
      if (edg.rising) begin m_ph[k] = 1; m_n[k] = 0; end
      else if (en) m_n[k]++;
    end else if (m_ph[k] == 1) begin
      if (edg.falling) begin
        m_caph[k] = cap_val(k, m_n[k]); m_caphs[k] = (m_n[k] > max_of(k));
        m_ph[k] = 2; m_n[k] = 0;
      end else if (edg.rising) m_n[k] = 0;
      else if (en) m_n[k]++;
    end else begin
      if (edg.rising) begin
        emit = 1'b1; elow = cap_val(k, m_n[k]);
        eovf = {m_n[k] > max_of(k), m_caphs[k]};
        m_ph[k] = 1; m_n[k] = 0;
      end else if (en && m_n[k] == P_TO[k] - 1) begin
        emit = 1'b1; eto = 1'b1; elow = P_TO[k]; eovf = {1'b0, m_caphs[k]};
        m_ph[k] = 0; m_n[k]++;
      end else if (en) m_n[k]++;
    end
    if (emit) begin
      if (m_vld[k] && !rdy) m_ovr[k] = 1'b1;
      else begin
        m_vld[k] = 1'b1; m_hi[k] = m_caph[k]; m_lo[k] = elow; m_ovf[k] = eovf; m_to[k] = eto;
      end
    end else if (rdy) m_vld[k] = 1'b0;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic check_all();
    int exp_t;
    for (int k = 0; k < 3; k++) begin
      exp_t = (m_ph[k] == 0) ? ((m_n[k] > max_of(k)) ? max_of(k) : m_n[k]) : cap_val(k, m_n[k]);
      chk($sformatf("model_valid%0d", k), int'(a_valid[k]), int'(m_vld[k]));
      chk($sformatf("model_overrun%0d", k), int'(a_ovr[k]), int'(m_ovr[k]));
      chk($sformatf("model_timer%0d", k), int'(a_timer[k]), exp_t);
      if (m_vld[k]) begin
        chk($sformatf("model_high%0d", k), int'(a_high[k]), m_hi[k]);
        chk($sformatf("model_low%0d", k), int'(a_low[k]), m_lo[k]);
        chk($sformatf("model_ovf%0d", k), int'(a_ovf[k]), int'(m_ovf[k]));
        chk($sformatf("model_timeout%0d", k), int'(a_to[k]), int'(m_to[k]));
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    #1;
    check_all();
  endtask

  task automatic edge_pulse(bit r, bit f);
    edg.rising = r; edg.falling = f;
    cycle();
    edg = '0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_clear();
    clr = 1'b1; cycle(); clr = 1'b0;
  endtask

  typedef struct {
    int dut; int gap_f; int gap_r; int high; int low; int ovf;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int waited;
    vecs[0] = '{0, 20, 30, 19, 29, 0};
    vecs[1] = '{1, 30, 5, 15, 4, 1};
    vecs[2] = '{2, 30, 5, 13, 4, 1};
    vecs[3] = '{0, 5, 7, 4, 6, 0};
    vecs[4] = '{1, 17, 3, 15, 2, 1};
    vecs[5] = '{2, 33, 4, 0, 3, 1};

    idle(3);
    for (int k = 0; k < 3; k++) begin
      chk("reset_valid", int'(a_valid[k]), 0);
      chk("reset_timer", int'(a_timer[k]), 0);
    end
    #2 rst_n = 1'b1; en = 1'b1; rdy = 1'b1;

    foreach (vecs[i]) begin
      do_clear();
      edge_pulse(1, 0); idle(vecs[i].gap_f - 1);
      edge_pulse(0, 1); idle(vecs[i].gap_r - 1);
      edge_pulse(1, 0);
      chk("tbl_valid", int'(a_valid[vecs[i].dut]), 1);
      chk("tbl_high", int'(a_high[vecs[i].dut]), vecs[i].high);
      chk("tbl_low", int'(a_low[vecs[i].dut]), vecs[i].low);
      chk("tbl_ovf", int'(a_ovf[vecs[i].dut]), vecs[i].ovf);
      chk("tbl_timeout", int'(a_to[vecs[i].dut]), 0);
      $display("vector %0d dut %0d: high %0d low %0d ovf %0d", i, vecs[i].dut,
               a_high[vecs[i].dut], a_low[vecs[i].dut], a_ovf[vecs[i].dut]);
    end

    // Timeout closes the frame 400 enabled cycles after the falling edge
    do_clear();
    edge_pulse(1, 0); idle(9); edge_pulse(0, 1);
    waited = 0;
    while (!a_valid[0] && waited < 600) begin cycle(); waited++; end
    chk("to_latency", waited, 400);
    chk("to_low", int'(a_low[0]), 400);
    chk("to_high", int'(a_high[0]), 9);
    chk("to_flag", int'(a_to[0]), 1);
    $display("timeout result: high %0d low %0d after %0d cycles", a_high[0], a_low[0], waited);
    edge_pulse(0, 1); idle(20);
    chk("to_idle_fall", int'(a_valid[0]), 0);
    edge_pulse(1, 0);
    chk("to_idle_rise", int'(a_valid[0]), 0);

    // Overrun: second result dropped while the first is held
    rdy = 1'b0;
    do_clear();
    edge_pulse(1, 0); idle(3); edge_pulse(0, 1); idle(3); edge_pulse(1, 0);
    idle(5); edge_pulse(0, 1); idle(5); edge_pulse(1, 0); idle(2);
    chk("ovr_valid", int'(a_valid[0]), 1);
    chk("ovr_high", int'(a_high[0]), 3);
    chk("ovr_low", int'(a_low[0]), 3);
    chk("ovr_flag", int'(a_ovr[0]), 1);
    do_clear();
    chk("ovr_clr_valid", int'(a_valid[0]), 0);
    chk("ovr_clr_flag", int'(a_ovr[0]), 0);
    rdy = 1'b1;

    // Illegal simultaneous edges send the FSM to IDLE
    do_clear();
    edge_pulse(1, 0); idle(5); edge_pulse(1, 1);
    chk("ill_timer", int'(a_timer[0]), 0);
    chk("ill_valid", int'(a_valid[0]), 0);
    edge_pulse(0, 1); idle(3); edge_pulse(1, 0);
    chk("ill_idle", int'(a_valid[0]), 0);

    // Asynchronous reset in the middle of a LOW phase
    rdy = 1'b0;
    do_clear();
    edge_pulse(1, 0); idle(2); edge_pulse(0, 1); idle(2); edge_pulse(1, 0);
    edge_pulse(0, 1); idle(3);
    chk("rst_pre_valid", int'(a_valid[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", int'(a_valid[k]), 0);
      chk("rst_high", int'(a_high[k]), 0);
      chk("rst_low", int'(a_low[k]), 0);
      chk("rst_ovf", int'(a_ovf[k]), 0);
      chk("rst_timeout", int'(a_to[k]), 0);
      chk("rst_overrun", int'(a_ovr[k]), 0);
      chk("rst_timer", int'(a_timer[k]), 0);
    end
    cycle();
    rst_n = 1'b1; rdy = 1'b1;
    edge_pulse(0, 1); idle(3); edge_pulse(1, 0);
    chk("rst_fresh", int'(a_valid[0]), 0);

    // Randomized run; quiet stretches let the long timeout fire
    for (int blk = 0; blk < 3; blk++) begin
      for (int i = 0; i < 1300; i++) begin
        en          = ($urandom_range(0, 7) != 0);
        rdy         = ($urandom_range(0, 3) != 0);
        clr         = ($urandom_range(0, 599) == 0);
        edg.falling = ($urandom_range(0, 29) == 0);
        edg.rising  = (i < 800) ? ($urandom_range(0, 29) == 0) : 1'b0;
        cycle();
      end
    end
    edg = '0; clr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
